// File: rtl/clint_pkg.sv
// Shared constants and types for the core-local interruptor: bus widths,
// register addresses, access size codes and response codes.
package clint_pkg;

    localparam int DATA_BUS      = 64;
    localparam int DATA_ADDR_BUS = 64;

    localparam logic [DATA_ADDR_BUS-1:0] MTIME_ADDR    = 64'h0000_0000_0200_BFF8;
    localparam logic [DATA_ADDR_BUS-1:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } clint_state_t;

endpackage

// File: rtl/clint_wmerge.sv
// Size-aware write merge: replaces the low 1/2/4/8 bytes of a 64-bit register
// with right-aligned write data and keeps the remaining upper bytes.
module clint_wmerge
    import clint_pkg::*;
(
    input  logic [63:0] reg_old,
    input  logic [63:0] wdata,
    input  logic [1:0]  size,
    output logic [63:0] reg_new
);

    always_comb begin
        reg_new = reg_old;
        case (size)
            SIZE_B:  reg_new[7:0]  = wdata[7:0];
            SIZE_H:  reg_new[15:0] = wdata[15:0];
            SIZE_W:  reg_new[31:0] = wdata[31:0];
            default: reg_new       = wdata;
        endcase
    end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp registers, mtime prescaler,
// single-beat valid/ready register access and the machine timer interrupt.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for a request; a valid request is accepted at the edge
//   ST_RESP | ready pulse; read data and resp are presented for one cycle
module clint
    import clint_pkg::*;
#(
    parameter int                         TICK_DIV   = 1,
    parameter logic [DATA_ADDR_BUS-1:0]   MTIME_A    = MTIME_ADDR,
    parameter logic [DATA_ADDR_BUS-1:0]   MTIMECMP_A = MTIMECMP_ADDR
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clint_valid_i,
    output logic                      clint_ready_o,
    input  logic                      clint_req_i,
    input  logic [DATA_ADDR_BUS-1:0]  clint_addr_i,
    input  logic [1:0]                clint_size_i,
    input  logic [DATA_BUS-1:0]       clint_data_write_i,
    output logic [DATA_BUS-1:0]       clint_data_read_o,
    output logic [1:0]                clint_resp_o,
    output logic                      clint_timer_irq_o
);

    localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    clint_state_t     state_q, state_d;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [63:0]      mtime, mtimecmp;
    logic [63:0]      mtime_wr, mtimecmp_wr;
    logic             accept;
    logic             sel_mtime, sel_mtimecmp;
    logic [63:0]      rdata_d;
    logic [1:0]       resp_d;

    assign tick         = (tick_cnt == TICK_LAST);
    assign sel_mtime    = (clint_addr_i == MTIME_A);
    assign sel_mtimecmp = (clint_addr_i == MTIMECMP_A);

    clint_wmerge u_wmerge_mtime (
        .reg_old (mtime),
        .wdata   (clint_data_write_i),
        .size    (clint_size_i),
        .reg_new (mtime_wr)
    );

    clint_wmerge u_wmerge_mtimecmp (
        .reg_old (mtimecmp),
        .wdata   (clint_data_write_i),
        .size    (clint_size_i),
        .reg_new (mtimecmp_wr)
    );

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        clint_ready_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clint_valid_i) begin
                    accept  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                clint_ready_o = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data reflects the registers before this edge's tick or write.
    always_comb begin
        rdata_d = '0;
        resp_d  = RESP_SLVERR;
        if (sel_mtime) begin
            rdata_d = mtime;
            resp_d  = RESP_OKAY;
        end else if (sel_mtimecmp) begin
            rdata_d = mtimecmp;
            resp_d  = RESP_OKAY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            tick_cnt          <= '0;
            mtime             <= '0;
            mtimecmp          <= '1;
            clint_timer_irq_o <= 1'b0;
            clint_data_read_o <= '0;
            clint_resp_o      <= RESP_OKAY;
        end else begin
            state_q           <= state_d;
            tick_cnt          <= tick ? '0 : tick_cnt + CNT_W'(1);
            clint_timer_irq_o <= (mtime >= mtimecmp);

            // A software write to mtime overrides the tick increment on the same edge.
            if (accept && clint_req_i && sel_mtime) begin
                mtime <= mtime_wr;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (accept && clint_req_i && sel_mtimecmp) begin
                mtimecmp <= mtimecmp_wr;
            end

            if (accept) begin
                clint_data_read_o <= rdata_d;
                clint_resp_o      <= resp_d;
            end
        end
    end

endmodule
